inst_fetch_memory: RTL and testbench
====================================

INST_FETCH_MEMORY -- requirements
Module: inst_fetch_memory

Interface
REQ-001 SHALL have parameter BYTE_W, default 8, meaning storage byte width in bits.
REQ-002 SHALL have parameter WORD_BYTES, default 4, meaning bytes per instruction word.
REQ-003 SHALL have parameter DEPTH, default 256, meaning storage size in bytes (multiple of WORD_BYTES).
REQ-004 SHALL have parameter ADR_W, default 32, meaning byte-address width.
REQ-005 SHALL have parameter READ_LAT, default 1, range 1..4, meaning cycles from request acceptance to response.
REQ-006 SHALL have parameter ALIGN_CHECK, default 1, meaning flag misaligned fetches as faults.
REQ-007 Ports (name dir width meaning):
- clk in 1: single clock, rising edge.
- rst_n in 1: asynchronous reset, active-low.
- load_mode in 1: request programming mode.
- load_we in 1: byte write strobe, honoured only in LOAD.
- load_adr in ADR_W: byte address of the write.
- load_byte in BYTE_W: write data.
- req_valid in 1: fetch request.
- req_ready out 1: fetch can be accepted.
- req_adr in ADR_W: fetch byte address.
- rsp_valid out 1: response available.
- rsp_ready in 1: response consumed.
- rsp_instr out WORD_BYTES*BYTE_W: fetched word, lowest address in MSBs (big-endian).
- rsp_fault out 1: misaligned or out-of-range fetch.
- flush in 1: discard in-flight fetch.

Function
REQ-008 FSM states: IDLE, LOAD, WAIT, RESP.
REQ-009 IDLE: req_ready=1 iff load_mode=0 and flush=0; a request is accepted on an edge with req_valid&&req_ready, and req_adr is captured there.
REQ-010 IDLE->LOAD when load_mode=1; load_mode takes priority over a simultaneous req_valid. LOAD->IDLE when load_mode=0.
REQ-011 LOAD: each edge with load_we=1 and load_adr<DEPTH writes load_byte to byte load_adr; load_adr>=DEPTH is dropped silently; req_ready=0.
REQ-012 Response latency: rsp_valid rises exactly READ_LAT edges after acceptance; READ_LAT=1 goes directly to RESP, otherwise WAIT counts READ_LAT-1 cycles.
REQ-013 RESP holds rsp_valid, rsp_instr and rsp_fault stable until the edge with rsp_ready=1, then returns to IDLE; no new request accepted while in RESP (req_ready=0).
REQ-014 Fault: adr+WORD_BYTES>DEPTH (computed without ADR_W overflow), or ALIGN_CHECK=1 and adr mod WORD_BYTES!=0; on fault rsp_fault=1 and rsp_instr=0. No address wrap-around.
REQ-015 Data: rsp_instr is the byte concatenation adr..adr+WORD_BYTES-1 as stored at the acceptance edge. A byte written on edge N is visible to a request accepted on edge N+1 or later.
REQ-016 flush=1 in WAIT or RESP returns to IDLE on that edge with rsp_valid=0 on the next cycle; flush in IDLE blocks acceptance; flush in LOAD is ignored.
REQ-017 load_mode asserted in WAIT/RESP is deferred until the FSM is back in IDLE.

Reset
REQ-018 rst_n=0 SHALL immediately force state IDLE, rsp_valid=0, rsp_fault=0, rsp_instr=0, wait counter 0, and req_ready to its IDLE value after release; in-flight fetches are lost.
REQ-019 Storage contents SHALL NOT be reset; contents before the first load are undefined.

Structure
REQ-020 The state enum and fault-cause encodings SHALL live in the shared CPU package; parameter defaults stay local.
REQ-021 Byte storage SHALL be one sub-module, byte_ram (one write port, WORD_BYTES-wide combinational read); FSM and fault logic stay in inst_fetch_memory.

Verification
REQ-022 Load 0x20,0x01,0x00,0x50 at bytes 0..3 (READ_LAT=1), fetch adr 0 -> rsp_valid next cycle, rsp_instr=0x20010050, rsp_fault=0.
REQ-023 READ_LAT=3, fetch adr 4, rsp_ready=0 for 5 cycles -> rsp_valid rises 3 edges after acceptance and the word stays stable until rsp_ready=1.
REQ-024 Fetch adr 254 (DEPTH=256) -> rsp_fault=1, rsp_instr=0; fetch adr 6 -> rsp_fault=1; ALIGN_CHECK=0, adr 6 -> fault=0.
REQ-025 READ_LAT=2, flush one cycle after acceptance -> no rsp_valid; next request accepted normally.
REQ-026 load_mode and req_valid asserted together in IDLE -> LOAD entered, req_ready=0, request not accepted.
REQ-027 rst_n pulsed low in WAIT -> rsp_valid=0 immediately; previously loaded bytes are still returned after release.

Source files
------------

// File: rtl/inst_fetch_memory_pkg.sv
// Shared encodings for the instruction-fetch memory: FSM states and fault causes.
package inst_fetch_memory_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    FAULT_NONE  = 2'd0,
    FAULT_RANGE = 2'd1,
    FAULT_ALIGN = 2'd2
  } fault_cause_e;

  // Wide enough for READ_LAT up to 4 (at most two extra WAIT cycles).
  localparam int unsigned WAIT_CNT_W = 2;

  // Range faults win over alignment faults when both apply.
  function automatic fault_cause_e fetch_cause(input logic range_bad, input logic align_bad);
    fault_cause_e cause;
    cause = FAULT_NONE;
    if (range_bad) begin
      cause = FAULT_RANGE;
    end else if (align_bad) begin
      cause = FAULT_ALIGN;
    end
    return cause;
  endfunction

endpackage

// File: rtl/inst_fetch_memory_byte_ram.sv
// Byte-wide storage: one write port, WORD_BYTES-wide combinational big-endian read.
module byte_ram #(
  parameter int BYTE_W     = 8,
  parameter int WORD_BYTES = 4,
  parameter int DEPTH      = 256,
  parameter int ADR_W      = 32,
  parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [IDX_W-1:0]             waddr,
  input  logic [BYTE_W-1:0]            wdata,
  input  logic [ADR_W-1:0]             raddr,
  output logic [WORD_BYTES*BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Lanes past the end read as zero so an out-of-range word never indexes outside mem.
  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
    logic [ADR_W:0] lane_adr;
    assign lane_adr = {1'b0, raddr} + (ADR_W+1)'(gi);
    assign rdata[(WORD_BYTES-1-gi)*BYTE_W +: BYTE_W] =
      (lane_adr < (ADR_W+1)'(DEPTH)) ? mem[lane_adr[IDX_W-1:0]] : '0;
  end

endmodule

// File: rtl/inst_fetch_memory.sv
// Instruction fetch memory: byte-programmable store with a latency-configurable,
// flushable fetch port that reports range/alignment faults.
module inst_fetch_memory
  import inst_fetch_memory_pkg::*;
#(
  parameter int BYTE_W      = 8,
  parameter int WORD_BYTES  = 4,
  parameter int DEPTH       = 256,
  parameter int ADR_W       = 32,
  parameter int READ_LAT    = 1,
  parameter int ALIGN_CHECK = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_mode,
  input  logic                         load_we,
  input  logic [ADR_W-1:0]             load_adr,
  input  logic [BYTE_W-1:0]            load_byte,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADR_W-1:0]             req_adr,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [WORD_BYTES*BYTE_W-1:0] rsp_instr,
  output logic                         rsp_fault,
  input  logic                         flush
);

  localparam int WORD_W = WORD_BYTES * BYTE_W;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
    (READ_LAT > 1) ? WAIT_CNT_W'(READ_LAT - 2) : '0;

  fetch_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_fault_q, rsp_fault_d;
  logic [WORD_W-1:0]       rsp_instr_q, rsp_instr_d;
  logic                    pend_fault_q, pend_fault_d;
  logic [WORD_W-1:0]       pend_instr_q, pend_instr_d;

  logic                    ram_we;
  logic [WORD_W-1:0]       ram_rdata;
  logic [ADR_W:0]          req_end;
  logic                    range_bad;
  logic                    align_bad;
  fault_cause_e            req_cause;
  logic                    req_fault;
  logic [WORD_W-1:0]       req_word;
  logic                    accept;

  // Writes beyond the store are dropped rather than aliased.
  assign ram_we = (state_q == ST_LOAD) && load_we &&
                  ({1'b0, load_adr} < (ADR_W+1)'(DEPTH));

  byte_ram #(
    .BYTE_W     (BYTE_W),
    .WORD_BYTES (WORD_BYTES),
    .DEPTH      (DEPTH),
    .ADR_W      (ADR_W),
    .IDX_W      (IDX_W)
  ) u_byte_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (load_adr[IDX_W-1:0]),
    .wdata (load_byte),
    .raddr (req_adr),
    .rdata (ram_rdata)
  );

  // End address is formed one bit wider so addresses near 2^ADR_W cannot wrap.
  assign req_end   = {1'b0, req_adr} + (ADR_W+1)'(WORD_BYTES);
  assign range_bad = req_end > (ADR_W+1)'(DEPTH);
  assign align_bad = (ALIGN_CHECK != 0) && ((req_adr % ADR_W'(WORD_BYTES)) != '0);
  assign req_cause = fetch_cause(range_bad, align_bad);
  assign req_fault = (req_cause != FAULT_NONE);
  assign req_word  = req_fault ? '0 : ram_rdata;

  assign req_ready = (state_q == ST_IDLE) && !load_mode && !flush;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_fault_d  = rsp_fault_q;
    rsp_instr_d  = rsp_instr_q;
    pend_fault_d = pend_fault_q;
    pend_instr_d = pend_instr_q;

    case (state_q)
      ST_IDLE: begin
        if (load_mode) begin
          state_d = ST_LOAD;
        end else if (accept) begin
          // The word is snapshotted here so later stores cannot alter it.
          pend_fault_d = req_fault;
          pend_instr_d = req_word;
          if (READ_LAT <= 1) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = req_fault;
            rsp_instr_d = req_word;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_INIT;
          end
        end
      end

      ST_LOAD: begin
        if (!load_mode) begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (flush) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == '0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_fault_d = pend_fault_q;
          rsp_instr_d = pend_instr_q;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end

      ST_RESP: begin
        if (flush || rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_fault_d = 1'b0;
          rsp_instr_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_fault_q  <= 1'b0;
      rsp_instr_q  <= '0;
      pend_fault_q <= 1'b0;
      pend_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_fault_q  <= rsp_fault_d;
      rsp_instr_q  <= rsp_instr_d;
      pend_fault_q <= pend_fault_d;
      pend_instr_q <= pend_instr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_instr = rsp_instr_q;

endmodule

// File: tb/tb_inst_fetch_memory.sv
// Directed bench: four instances (READ_LAT 1/3/2 and ALIGN_CHECK=0) sharing the load bus.
module tb_inst_fetch_memory;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_mode = 1'b0;
  logic        load_we = 1'b0;
  logic [31:0] load_adr = '0;
  logic [7:0]  load_byte = '0;

  logic        req_valid [4];
  logic [31:0] req_adr   [4];
  logic        rsp_ready [4];
  logic        flush     [4];
  logic        req_ready [4];
  logic        rsp_valid [4];
  logic        rsp_fault [4];
  logic [31:0] rsp_instr [4];

  logic [7:0]  img [12];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instance 0: defaults (READ_LAT=1, ALIGN_CHECK=1)
  inst_fetch_memory u_dut0 (
    .clk(clk), .rst_n(rst_n), .load_mode(load_mode), .load_we(load_we),
    .load_adr(load_adr), .load_byte(load_byte),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_adr(req_adr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_instr(rsp_instr[0]),
    .rsp_fault(rsp_fault[0]), .flush(flush[0])
  );

  inst_fetch_memory #(.READ_LAT(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load_mode(load_mode), .load_we(load_we),
    .load_adr(load_adr), .load_byte(load_byte),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_adr(req_adr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_instr(rsp_instr[1]),
    .rsp_fault(rsp_fault[1]), .flush(flush[1])
  );

  inst_fetch_memory #(.READ_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .load_mode(load_mode), .load_we(load_we),
    .load_adr(load_adr), .load_byte(load_byte),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_adr(req_adr[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_instr(rsp_instr[2]),
    .rsp_fault(rsp_fault[2]), .flush(flush[2])
  );

  inst_fetch_memory #(.ALIGN_CHECK(0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .load_mode(load_mode), .load_we(load_we),
    .load_adr(load_adr), .load_byte(load_byte),
    .req_valid(req_valid[3]), .req_ready(req_ready[3]), .req_adr(req_adr[3]),
    .rsp_valid(rsp_valid[3]), .rsp_ready(rsp_ready[3]), .rsp_instr(rsp_instr[3]),
    .rsp_fault(rsp_fault[3]), .flush(flush[3])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [31:0] adr, input logic [7:0] b);
    load_we   = 1'b1;
    load_adr  = adr;
    load_byte = b;
    tick();
    load_we   = 1'b0;
  endtask

  // Full fetch handshake on instance i with the response consumed immediately.
  task automatic fetch(input int i, input logic [31:0] adr, input int lat,
                       input logic [31:0] exp_instr, input logic exp_fault, input string tag);
    chk1({tag, "_ready"}, req_ready[i], 1'b1);
    req_valid[i] = 1'b1;
    req_adr[i]   = adr;
    tick();
    req_valid[i] = 1'b0;
    for (int c = 1; c < lat; c++) begin
      chk1({tag, "_early"}, rsp_valid[i], 1'b0);
      tick();
    end
    chk1({tag, "_valid"}, rsp_valid[i], 1'b1);
    chk({tag, "_instr"}, rsp_instr[i], exp_instr);
    chk1({tag, "_fault"}, rsp_fault[i], exp_fault);
    rsp_ready[i] = 1'b1;
    tick();
    rsp_ready[i] = 1'b0;
    chk1({tag, "_done"}, rsp_valid[i], 1'b0);
    $display("fetch %s inst=%0d adr=%h instr=%h fault=%b", tag, i, adr, exp_instr, exp_fault);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = 1'b0;
      req_adr[i]   = '0;
      rsp_ready[i] = 1'b0;
      flush[i]     = 1'b0;
    end
    img = '{8'h20, 8'h01, 8'h00, 8'h50, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
            8'h11, 8'h22, 8'h33, 8'h44};

    // Reset state
    repeat (2) tick();
    chk1("rst_valid", rsp_valid[0], 1'b0);
    chk1("rst_fault", rsp_fault[0], 1'b0);
    chk("rst_instr", rsp_instr[0], 32'h0);
    rst_n = 1'b1;
    tick();
    chk1("rst_ready", req_ready[0], 1'b1);

    // Program bytes 0..11 and 252..255
    load_mode = 1'b1;
    tick();
    chk1("load_ready", req_ready[0], 1'b0);
    for (int k = 0; k < 12; k++) write_byte(32'(k), img[k]);
    write_byte(32'd252, 8'hA1);
    write_byte(32'd253, 8'hB2);
    write_byte(32'd254, 8'hC3);
    write_byte(32'd255, 8'hD4);
    load_mode = 1'b0;
    tick();
    $display("load done");

    // Basic fetch with READ_LAT=1
    fetch(0, 32'd0, 1, 32'h20010050, 1'b0, "rl1_adr0");

    // READ_LAT=3 with response held off for 5 cycles
    req_valid[1] = 1'b1;
    req_adr[1]   = 32'd4;
    tick();
    req_valid[1] = 1'b0;
    chk1("rl3_e0_valid", rsp_valid[1], 1'b0);
    chk1("rl3_e0_ready", req_ready[1], 1'b0);
    tick();
    chk1("rl3_e1_valid", rsp_valid[1], 1'b0);
    tick();
    chk1("rl3_e2_valid", rsp_valid[1], 1'b1);
    chk("rl3_e2_instr", rsp_instr[1], 32'hDEADBEEF);
    chk1("rl3_e2_fault", rsp_fault[1], 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk1("rl3_hold_valid", rsp_valid[1], 1'b1);
      chk("rl3_hold_instr", rsp_instr[1], 32'hDEADBEEF);
    end
    rsp_ready[1] = 1'b1;
    tick();
    rsp_ready[1] = 1'b0;
    chk1("rl3_done_valid", rsp_valid[1], 1'b0);
    chk1("rl3_done_ready", req_ready[1], 1'b1);
    $display("fetch rl3_adr4 held five cycles");

    // Fault cases
    fetch(0, 32'd254, 1, 32'h0, 1'b1, "range_adr254");
    fetch(0, 32'd6, 1, 32'h0, 1'b1, "align_adr6");
    fetch(3, 32'd6, 1, 32'hBEEF1122, 1'b0, "noalign_adr6");
    fetch(0, 32'd252, 1, 32'hA1B2C3D4, 1'b0, "edge_adr252");
    fetch(3, 32'd253, 1, 32'h0, 1'b1, "noalign_adr253");
    fetch(0, 32'hFFFFFFFC, 1, 32'h0, 1'b1, "no_wrap");

    // Flush one cycle after acceptance at READ_LAT=2
    req_valid[2] = 1'b1;
    req_adr[2]   = 32'd0;
    tick();
    req_valid[2] = 1'b0;
    flush[2]     = 1'b1;
    tick();
    flush[2]     = 1'b0;
    chk1("flush_wait_valid0", rsp_valid[2], 1'b0);
    tick();
    chk1("flush_wait_valid1", rsp_valid[2], 1'b0);
    chk1("flush_wait_ready", req_ready[2], 1'b1);
    $display("flush in WAIT dropped fetch");
    fetch(2, 32'd8, 2, 32'h11223344, 1'b0, "rl2_after_flush");

    // Flush while in RESP
    req_valid[0] = 1'b1;
    req_adr[0]   = 32'd0;
    tick();
    req_valid[0] = 1'b0;
    chk1("flush_resp_pre", rsp_valid[0], 1'b1);
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    chk1("flush_resp_post", rsp_valid[0], 1'b0);
    $display("flush in RESP dropped response");

    // Flush in IDLE blocks acceptance
    flush[0]     = 1'b1;
    req_valid[0] = 1'b1;
    chk1("flush_idle_ready", req_ready[0], 1'b0);
    tick();
    flush[0]     = 1'b0;
    req_valid[0] = 1'b0;
    chk1("flush_idle_valid", rsp_valid[0], 1'b0);
    $display("flush in IDLE blocked request");

    // load_mode beats a simultaneous request; out-of-range write dropped
    load_mode    = 1'b1;
    req_valid[0] = 1'b1;
    req_adr[0]   = 32'd4;
    chk1("loadprio_ready_pre", req_ready[0], 1'b0);
    tick();
    req_valid[0] = 1'b0;
    chk1("loadprio_ready", req_ready[0], 1'b0);
    chk1("loadprio_valid", rsp_valid[0], 1'b0);
    write_byte(32'h100, 8'h99);
    // Write on the edge that leaves LOAD is still honoured
    load_we   = 1'b1;
    load_adr  = 32'd3;
    load_byte = 8'h51;
    load_mode = 1'b0;
    tick();
    load_we   = 1'b0;
    chk1("loadprio_no_rsp", rsp_valid[0], 1'b0);
    $display("load priority over request");
    fetch(0, 32'd0, 1, 32'h20010051, 1'b0, "post_load");

    // load_mode deferred while a fetch is in flight
    req_valid[1] = 1'b1;
    req_adr[1]   = 32'd8;
    tick();
    req_valid[1] = 1'b0;
    load_mode    = 1'b1;
    tick();
    chk1("defer_e1_valid", rsp_valid[1], 1'b0);
    tick();
    chk1("defer_e2_valid", rsp_valid[1], 1'b1);
    chk("defer_e2_instr", rsp_instr[1], 32'h11223344);
    rsp_ready[1] = 1'b1;
    tick();
    rsp_ready[1] = 1'b0;
    chk1("defer_done", rsp_valid[1], 1'b0);
    tick();
    load_mode = 1'b0;
    tick();
    chk1("defer_idle_ready", req_ready[1], 1'b1);
    $display("load_mode deferred during fetch");

    // Asynchronous reset mid-fetch: inst0 in RESP, inst1 in WAIT
    req_valid[0] = 1'b1;
    req_adr[0]   = 32'd4;
    req_valid[1] = 1'b1;
    req_adr[1]   = 32'd4;
    tick();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    chk1("arst_pre_valid", rsp_valid[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("arst_valid", rsp_valid[0], 1'b0);
    chk("arst_instr", rsp_instr[0], 32'h0);
    chk1("arst_fault", rsp_fault[0], 1'b0);
    tick();
    rst_n = 1'b1;
    chk1("arst_ready", req_ready[0], 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk1("arst_lost_fetch", rsp_valid[1], 1'b0);
    end
    $display("async reset cleared in-flight fetches");
    fetch(1, 32'd4, 3, 32'hDEADBEEF, 1'b0, "post_reset_rl3");
    fetch(0, 32'd0, 1, 32'h20010051, 1'b0, "post_reset_rl1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
